flex_mode_counter: RTL and testbench

FLEX_MODE_COUNTER -- requirements
Module: flex_mode_counter

---
 rtl/flex_cnt_pkg.sv | 27 ++
 rtl/flex_cnt_next.sv | 100 ++++++++++
 rtl/flex_mode_counter.sv | 75 +++++++
 tb/tb_flex_mode_counter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_cnt_pkg.sv
// flex_cnt_pkg
//   Shared types and helpers for the flex_mode_counter block.
//   mode_t       : terminal behaviour selected by the 2-bit mode input
//   decode_mode  : maps the raw mode bits onto mode_t. The reserved encoding
//                  behaves exactly like WRAP.
package flex_cnt_pkg;

  localparam int unsigned MODE_BITS = 2;

  typedef enum logic [MODE_BITS-1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  function automatic mode_t decode_mode(input logic [MODE_BITS-1:0] raw);
    mode_t m;
    case (raw)
      2'b01:   m = MODE_SAT;
      2'b10:   m = MODE_ONESHOT;
      default: m = MODE_WRAP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flex_cnt_next.sv
// flex_cnt_next
//   Purely combinational next-state logic for flex_mode_counter.
//   Inputs : count_i (current count), done_i (current sticky done),
//            clear_i / load_i / count_enable_i commands, up_down_i direction,
//            load_val_i, rollover_val_i, mode_i (raw 2-bit mode)
//   Outputs: count_o, rollover_flag_o, wrap_pulse_o, done_o -- the values the
//            top-level registers capture on the next rising clock edge.
module flex_cnt_next #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic [NUM_CNT_BITS-1:0] count_i,
  input  logic                    done_i,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic                    count_enable_i,
  input  logic                    up_down_i,
  input  logic [NUM_CNT_BITS-1:0] load_val_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  input  logic [1:0]              mode_i,
  output logic [NUM_CNT_BITS-1:0] count_o,
  output logic                    rollover_flag_o,
  output logic                    wrap_pulse_o,
  output logic                    done_o
);

  import flex_cnt_pkg::*;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  mode_t                   mode;
  logic [NUM_CNT_BITS-1:0] terminal;
  logic                    at_term;
  logic                    rv_zero;

  always_comb begin
    mode     = decode_mode(mode_i);
    // Terminal value follows the direction: top of range going up, 1 going down.
    terminal = up_down_i ? rollover_val_i : CNT_ONE;
    rv_zero  = (rollover_val_i == '0);
    at_term  = 1'b0;

    count_o      = count_i;
    wrap_pulse_o = 1'b0;
    done_o       = done_i;

    if (clear_i) begin
      count_o = '0;
      done_o  = 1'b0;
    end else if (load_i) begin
      count_o = load_val_i;
      done_o  = 1'b0;
    end else if (count_enable_i) begin
      if (rv_zero) begin
        // A zero range pins the counter at 0 with every status bit quiet.
        count_o = '0;
        done_o  = 1'b0;
      end else begin
        if (up_down_i) begin
          if (count_i < rollover_val_i) begin
            count_o = count_i + CNT_ONE;
          end else begin
            at_term = 1'b1;
          end
        end else begin
          // Out-of-range counts (0 or above the rollover value) re-enter at
          // the top of the range instead of wrapping through 2**N.
          if ((count_i == '0) || (count_i > rollover_val_i)) begin
            count_o = rollover_val_i;
          end else if (count_i == CNT_ONE) begin
            at_term = 1'b1;
          end else begin
            count_o = count_i - CNT_ONE;
          end
        end

        if (at_term) begin
          case (mode)
            MODE_SAT, MODE_ONESHOT: begin
              count_o = terminal;
            end
            default: begin
              count_o      = up_down_i ? CNT_ONE : rollover_val_i;
              wrap_pulse_o = 1'b1;
            end
          endcase
        end

        // ONESHOT completes as soon as a step lands on the terminal value, so
        // done rises together with the first arrival there and then sticks.
        if ((mode == MODE_ONESHOT) && (count_o == terminal)) begin
          done_o = 1'b1;
        end
      end
    end

    // Flag tracks the value about to be registered, so it lines up with count_out.
    rollover_flag_o = !clear_i && !rv_zero && (count_o == terminal);
  end

endmodule

// File: rtl/flex_mode_counter.sv
// flex_mode_counter
//   Up/down counter with selectable terminal behaviour (WRAP, SATURATE,
//   ONESHOT). All outputs are registered.
//   clk, n_rst            : clock and asynchronous active-low reset
//   clear, load,
//   count_enable          : commands, priority clear > load > enable > hold
//   up_down               : 1 = count up, 0 = count down
//   load_val              : value written by load
//   rollover_val          : upper terminal value of the range
//   mode                  : 00 WRAP, 01 SATURATE, 10 ONESHOT, 11 as WRAP
//   count_out             : current count
//   rollover_flag         : high while count_out sits at the active terminal
//   wrap_pulse            : one-cycle pulse on each WRAP-mode wrap
//   done                  : sticky ONESHOT completion
module flex_mode_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  logic [1:0]              mode,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse,
  output logic                    done
);

  logic [NUM_CNT_BITS-1:0] count_d, count_q;
  logic                    rollover_flag_d, rollover_flag_q;
  logic                    wrap_pulse_d, wrap_pulse_q;
  logic                    done_d, done_q;

  flex_cnt_next #(
    .NUM_CNT_BITS(NUM_CNT_BITS)
  ) u_next (
    .count_i        (count_q),
    .done_i         (done_q),
    .clear_i        (clear),
    .load_i         (load),
    .count_enable_i (count_enable),
    .up_down_i      (up_down),
    .load_val_i     (load_val),
    .rollover_val_i (rollover_val),
    .mode_i         (mode),
    .count_o        (count_d),
    .rollover_flag_o(rollover_flag_d),
    .wrap_pulse_o   (wrap_pulse_d),
    .done_o         (done_d)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q         <= '0;
      rollover_flag_q <= 1'b0;
      wrap_pulse_q    <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      count_q         <= count_d;
      rollover_flag_q <= rollover_flag_d;
      wrap_pulse_q    <= wrap_pulse_d;
      done_q          <= done_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = rollover_flag_q;
  assign wrap_pulse    = wrap_pulse_q;
  assign done          = done_q;

endmodule

// File: tb/tb_flex_mode_counter.sv
// tb_flex_mode_counter
//   Directed scenarios followed by a randomized run, all checked against a
//   behavioural model of the counter held in plain integers.
module tb_flex_mode_counter;

  localparam int W = 4;

  logic         clk;
  logic         n_rst;
  logic         clear;
  logic         count_enable;
  logic         up_down;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] rollover_val;
  logic [1:0]   mode;
  logic [W-1:0] count_out;
  logic         rollover_flag;
  logic         wrap_pulse;
  logic         done;

  int n_cmp;
  int n_fail;

  // Behavioural model state
  int m_cnt;
  bit m_flag;
  bit m_pulse;
  bit m_done;

  flex_mode_counter #(
    .NUM_CNT_BITS(W)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .up_down      (up_down),
    .load         (load),
    .load_val     (load_val),
    .rollover_val (rollover_val),
    .mode         (mode),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of the counter, described in terms of overflow/underflow of a
  // plain integer range 1..rv rather than a terminal-compare datapath.
  task automatic modelStep(input bit c, input bit l, input bit e, input bit ud,
                           input int lv, input int rv, input int md);
    int nxt;
    int term;
    bit wraps;
    wraps   = (md == 0) || (md == 3);
    m_pulse = 1'b0;
    if (c) begin
      m_cnt  = 0;
      m_done = 1'b0;
    end else if (l) begin
      m_cnt  = lv;
      m_done = 1'b0;
    end else if (e) begin
      if (rv == 0) begin
        m_cnt  = 0;
        m_done = 1'b0;
      end else if (ud) begin
        nxt = m_cnt + 1;
        if (nxt > rv) begin
          if (wraps) begin
            nxt     = 1;
            m_pulse = 1'b1;
          end else begin
            nxt = rv;
          end
        end
        m_cnt = nxt;
      end else begin
        if (m_cnt == 0 || m_cnt > rv) begin
          nxt = rv;
        end else begin
          nxt = m_cnt - 1;
          if (nxt == 0) begin
            if (wraps) begin
              nxt     = rv;
              m_pulse = 1'b1;
            end else begin
              nxt = 1;
            end
          end
        end
        m_cnt = nxt;
      end
      term = ud ? rv : 1;
      if (md == 2 && rv != 0 && m_cnt == term) m_done = 1'b1;
    end
    term   = ud ? rv : 1;
    m_flag = !c && (rv != 0) && (m_cnt == term);
  endtask

  task automatic modelReset();
    m_cnt   = 0;
    m_flag  = 1'b0;
    m_pulse = 1'b0;
    m_done  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model and step past the edge.
  task automatic applyStimulus(input bit c, input bit l, input bit e, input bit ud,
                               input int lv, input int rv, input int md);
    clear        = c;
    load         = l;
    count_enable = e;
    up_down      = ud;
    load_val     = W'(lv);
    rollover_val = W'(rv);
    mode         = 2'(md);
    modelStep(c, l, e, ud, lv, rv, md);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [W-1:0] exp_cnt;
    exp_cnt = m_cnt[W-1:0];
    n_cmp++;
    assert (count_out === exp_cnt) else begin
      n_fail++;
      $error("[TB] FAIL %s count_out observed=%0d expected=%0d", tag, count_out, exp_cnt);
    end
    n_cmp++;
    assert (rollover_flag === m_flag) else begin
      n_fail++;
      $error("[TB] FAIL %s rollover_flag observed=%0b expected=%0b", tag, rollover_flag, m_flag);
    end
    n_cmp++;
    assert (wrap_pulse === m_pulse) else begin
      n_fail++;
      $error("[TB] FAIL %s wrap_pulse observed=%0b expected=%0b", tag, wrap_pulse, m_pulse);
    end
    n_cmp++;
    assert (done === m_done) else begin
      n_fail++;
      $error("[TB] FAIL %s done observed=%0b expected=%0b", tag, done, m_done);
    end
  endtask

  initial begin
    int exp_wrap_seq[6];
    int r;
    bit rc, rl, re, rud;
    int rlv, rrv, rmd;
    logic [W-1:0] exp_seq_val;

    n_cmp  = 0;
    n_fail = 0;
    exp_wrap_seq = '{1, 2, 3, 4, 1, 2};

    n_rst        = 1'b0;
    clear        = 1'b0;
    count_enable = 1'b0;
    up_down      = 1'b1;
    load         = 1'b0;
    load_val     = '0;
    rollover_val = '0;
    mode         = 2'b00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    n_rst = 1'b1;

    // WRAP, up, range 1..4
    $display("[TB] wrap up rv=4");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 1, 0, 4, 0);
      checkOutput("wrap_up");
      exp_seq_val = W'(exp_wrap_seq[i]);
      n_cmp++;
      assert (count_out === exp_seq_val) else begin
        n_fail++;
        $error("[TB] FAIL wrap_seq[%0d] count_out observed=%0d expected=%0d", i, count_out, exp_seq_val);
      end
    end

    // SATURATE, down, load 3, range 1..5
    $display("[TB] saturate down");
    applyStimulus(0, 1, 0, 0, 3, 5, 1);
    checkOutput("sat_load");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 0, 3, 5, 1);
      checkOutput("sat_down");
    end

    // ONESHOT, up, range 1..2, then reload with 0
    $display("[TB] oneshot up");
    applyStimulus(1, 0, 0, 1, 0, 2, 2);
    checkOutput("os_clear");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 1, 0, 2, 2);
      checkOutput("os_up");
    end
    applyStimulus(0, 1, 0, 1, 0, 2, 2);
    checkOutput("os_reload");

    // Command priority
    $display("[TB] priority");
    applyStimulus(1, 1, 1, 1, 7, 9, 2);
    checkOutput("prio_clear");
    applyStimulus(0, 1, 1, 1, 7, 9, 2);
    checkOutput("prio_load");

    // Rollover value lowered below the count, then zeroed
    $display("[TB] rollover change");
    applyStimulus(0, 1, 0, 1, 6, 8, 0);
    checkOutput("rv_load6");
    applyStimulus(0, 0, 1, 1, 0, 3, 0);
    checkOutput("rv_lower");
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    checkOutput("rv_zero");

    // Asynchronous reset in the middle of a cycle
    $display("[TB] async reset");
    applyStimulus(0, 1, 0, 1, 5, 8, 0);
    checkOutput("ar_load5");
    applyStimulus(0, 0, 0, 1, 5, 8, 0);
    checkOutput("ar_hold");
    #2;
    n_rst = 1'b0;
    modelReset();
    #1;
    checkOutput("ar_immediate");
    @(posedge clk);
    #1;
    checkOutput("ar_held");
    n_rst = 1'b1;
    applyStimulus(0, 0, 1, 1, 0, 8, 0);
    checkOutput("ar_restart");

    // Randomized run
    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      r   = int'($urandom_range(0, 31));
      rc  = (r == 0);
      rl  = (r >= 1 && r <= 3);
      re  = ($urandom_range(0, 3) != 0);
      rud = 1'($urandom_range(0, 1));
      rlv = int'($urandom_range(0, 15));
      rrv = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 15));
      rmd = int'($urandom_range(0, 3));
      applyStimulus(rc, rl, re, rud, rlv, rrv, rmd);
      checkOutput("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
